// File: rtl/obi_wishbone_bridge.sv
// Bridges a core req/gnt/rvalid memory port to a Wishbone classic master, one transaction at a time.
// Optional bus-cycle watchdog enabled by defining BRIDGE_TIMEOUT_EN.
module obi_wishbone_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int ALIGN_ADDR     = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic [ADDR_WIDTH-1:0]   wb_addr_o,
    output logic [DATA_WIDTH-1:0]   wb_data_o,
    input  logic [DATA_WIDTH-1:0]   wb_data_i,
    input  logic                    wb_ack_i
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK =
        (ALIGN_ADDR != 0) ? ({ADDR_WIDTH{1'b1}} << OFF_W) : {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;
    logic [BE_W-1:0]         be_q, be_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;

`ifdef BRIDGE_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout_hit;

    // The cycle whose count equals CNT_LAST is the last BUS cycle allowed.
    assign timeout_hit = (cnt_q == CNT_LAST);
`endif

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        be_d    = be_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        gnt_o   = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    we_d    = we_i;
                    be_d    = be_i;
                    addr_d  = addr_i & ADDR_MASK;
                    wdata_d = wdata_i;
                    state_d = S_BUS;
`ifdef BRIDGE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            S_BUS: begin
                // An ack in the expiry cycle still completes normally.
                if (wb_ack_i) begin
                    rdata_d = we_q ? '0 : wb_data_i;
                    state_d = S_RESP;
`ifdef BRIDGE_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (timeout_hit) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            be_q    <= be_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Bus and response outputs decode straight from flops so reset drops them asynchronously.
    assign wb_cyc_o  = (state_q == S_BUS);
    assign wb_stb_o  = (state_q == S_BUS);
    assign wb_we_o   = we_q;
    assign wb_sel_o  = be_q;
    assign wb_addr_o = addr_q;
    assign wb_data_o = wdata_q;
    assign rvalid_o  = (state_q == S_RESP);
    assign rdata_o   = rdata_q;
`ifdef BRIDGE_TIMEOUT_EN
    assign err_o     = (state_q == S_RESP) & err_q;
`else
    assign err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_obi_wishbone_bridge.sv
// Directed bench for obi_wishbone_bridge: inputs change on the falling edge,
// outputs are checked 1 ns later; timeout cases only when BRIDGE_TIMEOUT_EN is defined.
module tb_obi_wishbone_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_addr_o;
  logic [31:0] wb_data_o;
  logic [31:0] wb_data_i;
  logic        wb_ack_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  obi_wishbone_bridge #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .ALIGN_ADDR     (1),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .we_i      (we_i),
    .be_i      (be_i),
    .addr_i    (addr_i),
    .wdata_i   (wdata_i),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .err_o     (err_o),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_sel_o  (wb_sel_o),
    .wb_addr_o (wb_addr_o),
    .wb_data_o (wb_data_o),
    .wb_data_i (wb_data_i),
    .wb_ack_i  (wb_ack_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    // clock/reset
    rst_n = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = 4'h0; addr_i = '0; wdata_i = '0;
    wb_data_i = '0; wb_ack_i = 1'b0;
    #3;
    chk("rst_gnt", gnt_o, 0);         chk("rst_rvalid", rvalid_o, 0);
    chk("rst_rdata", rdata_o, 0);     chk("rst_err", err_o, 0);
    chk("rst_cyc", wb_cyc_o, 0);      chk("rst_stb", wb_stb_o, 0);
    chk("rst_we", wb_we_o, 0);        chk("rst_sel", wb_sel_o, 0);
    chk("rst_addr", wb_addr_o, 0);    chk("rst_wdata", wb_data_o, 0);
    nxt(); nxt(); rst_n = 1'b1;
    nxt();

    // 1: single read, immediate ack
    req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h100;
    #1 chk("t1_gnt", gnt_o, 1); chk("t1_cyc_idle", wb_cyc_o, 0);
    nxt(); req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'hCAFEF00D;
    #1 chk("t1_cyc", wb_cyc_o, 1); chk("t1_stb", wb_stb_o, 1); chk("t1_gnt_bus", gnt_o, 0);
    chk("t1_addr", wb_addr_o, 32'h100); chk("t1_we", wb_we_o, 0); chk("t1_sel", wb_sel_o, 4'hF);
    chk("t1_rvalid_bus", rvalid_o, 0);
    nxt(); wb_ack_i = 1'b0; wb_data_i = '0;
    #1 chk("t1_rvalid", rvalid_o, 1); chk("t1_rdata", rdata_o, 32'hCAFEF00D);
    chk("t1_err", err_o, 0); chk("t1_cyc_resp", wb_cyc_o, 0);
    nxt();
    #1 chk("t1_rvalid_end", rvalid_o, 0); chk("t1_rdata_hold", rdata_o, 32'hCAFEF00D);

    // 2: write, ack after 3 cycles; request fields scrambled after grant
    nxt(); req_i = 1'b1; we_i = 1'b1; be_i = 4'b0011; addr_i = 32'h202; wdata_i = 32'h1234ABCD;
    #1 chk("t2_gnt", gnt_o, 1);
    nxt(); we_i = 1'b0; be_i = 4'hF; addr_i = 32'hFFC; wdata_i = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        req_i = 1'b0; wb_ack_i = 1'b1;
      end
      #1 chk("t2_cyc", wb_cyc_o, 1); chk("t2_we", wb_we_o, 1); chk("t2_sel", wb_sel_o, 4'b0011);
      chk("t2_addr", wb_addr_o, 32'h200); chk("t2_wdata", wb_data_o, 32'h1234ABCD);
      chk("t2_gnt_bus", gnt_o, 0); chk("t2_rvalid_bus", rvalid_o, 0);
      nxt();
    end
    wb_ack_i = 1'b0;
    #1 chk("t2_rvalid", rvalid_o, 1); chk("t2_rdata", rdata_o, 0); chk("t2_err", err_o, 0);
    chk("t2_gnt_resp", gnt_o, 0); chk("t2_cyc_resp", wb_cyc_o, 0);
    nxt();
    #1 chk("t2_rvalid_end", rvalid_o, 0);

    // 3: back-to-back reads with req held high
    nxt(); req_i = 1'b1; we_i = 1'b0; be_i = 4'hF; addr_i = 32'h300;
    #1 chk("t3_gnt1", gnt_o, 1);
    nxt(); addr_i = 32'h304; wb_ack_i = 1'b1; wb_data_i = 32'h11111111;
    #1 chk("t3_addr1", wb_addr_o, 32'h300); chk("t3_gnt_bus", gnt_o, 0);
    nxt(); wb_ack_i = 1'b0; wb_data_i = '0;
    #1 chk("t3_rvalid1", rvalid_o, 1); chk("t3_rdata1", rdata_o, 32'h11111111);
    chk("t3_gnt_resp", gnt_o, 0);
    nxt();
    #1 chk("t3_gnt2", gnt_o, 1); chk("t3_rvalid_gap", rvalid_o, 0);
    nxt(); req_i = 1'b0; wb_ack_i = 1'b1; wb_data_i = 32'h22222222;
    #1 chk("t3_addr2", wb_addr_o, 32'h304); chk("t3_cyc2", wb_cyc_o, 1);
    nxt(); wb_ack_i = 1'b0; wb_data_i = '0;
    #1 chk("t3_rvalid2", rvalid_o, 1); chk("t3_rdata2", rdata_o, 32'h22222222);
    nxt();

    // 4: stray ack while idle
    wb_ack_i = 1'b1; wb_data_i = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t4_rvalid", rvalid_o, 0); chk("t4_cyc", wb_cyc_o, 0);
      chk("t4_rdata", rdata_o, 32'h22222222);
      nxt();
    end
    wb_ack_i = 1'b0; wb_data_i = '0;

    // 5: reset in the middle of a bus cycle
    req_i = 1'b1; we_i = 1'b1; be_i = 4'hF; addr_i = 32'h400; wdata_i = 32'h55;
    #1 chk("t5_gnt", gnt_o, 1);
    nxt(); req_i = 1'b0;
    #1 chk("t5_cyc", wb_cyc_o, 1);
    #2 rst_n = 1'b0;
    #1 chk("t5_cyc_rst", wb_cyc_o, 0); chk("t5_stb_rst", wb_stb_o, 0);
    chk("t5_rvalid_rst", rvalid_o, 0); chk("t5_rdata_rst", rdata_o, 0);
    chk("t5_addr_rst", wb_addr_o, 0); chk("t5_wdata_rst", wb_data_o, 0);
    chk("t5_we_rst", wb_we_o, 0); chk("t5_sel_rst", wb_sel_o, 0);
    chk("t5_gnt_rst", gnt_o, 0); chk("t5_err_rst", err_o, 0);
    nxt(); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t5_rvalid_after", rvalid_o, 0); chk("t5_cyc_after", wb_cyc_o, 0);
      nxt();
    end

`ifdef BRIDGE_TIMEOUT_EN
    // 6: watchdog expiry, then ack in the expiry cycle
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h500;
    #1 chk("t6_gnt", gnt_o, 1);
    nxt(); req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t6_cyc", wb_cyc_o, 1);
      nxt();
    end
    #1 chk("t6_cyc_drop", wb_cyc_o, 0); chk("t6_rvalid", rvalid_o, 1);
    chk("t6_err", err_o, 1); chk("t6_rdata", rdata_o, 0);
    nxt();
    #1 chk("t6_err_end", err_o, 0);
    nxt(); req_i = 1'b1; addr_i = 32'h504;
    #1 chk("t6b_gnt", gnt_o, 1);
    nxt(); req_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        wb_ack_i = 1'b1; wb_data_i = 32'h00000077;
      end
      #1 chk("t6b_cyc", wb_cyc_o, 1);
      nxt();
    end
    wb_ack_i = 1'b0;
    #1 chk("t6b_rvalid", rvalid_o, 1); chk("t6b_err", err_o, 0);
    chk("t6b_rdata", rdata_o, 32'h00000077);
    nxt();
`else
    // 6: without the watchdog the bus waits indefinitely for ack
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h500;
    #1 chk("t6_gnt", gnt_o, 1);
    nxt(); req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1 chk("t6_cyc_wait", wb_cyc_o, 1); chk("t6_rvalid_wait", rvalid_o, 0);
      nxt();
    end
    wb_ack_i = 1'b1; wb_data_i = 32'h5A5A5A5A;
    nxt(); wb_ack_i = 1'b0;
    #1 chk("t6_rvalid", rvalid_o, 1); chk("t6_err", err_o, 0);
    chk("t6_rdata", rdata_o, 32'h5A5A5A5A);
    nxt();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
